// File: rtl/branch_pkg.sv
// Shared branch-resolution types: funct3 encodings and the registered result.
// XLEN fixes the PC/target width for every file importing this package.
package branch_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } funct3_e;

    typedef struct packed {
        logic            taken;
        logic            mispredict;
        logic            illegal;
        logic [XLEN-1:0] redirect_pc;
    } br_result_t;

endpackage

// File: rtl/br_skid2.sv
// Generic 2-entry skid buffer: main (output) register plus one skid slot.
// Upstream ready depends only on skid occupancy and flush, never on out_ready.
module br_skid2 #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic reset_n,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic main_v;
    logic skid_v;
    T     main_d;
    T     skid_d;
    logic accept;
    logic drain;

    assign in_ready  = !skid_v && !flush;
    assign accept    = in_valid && in_ready;
    assign drain     = main_v && out_ready;
    assign out_valid = main_v;
    assign out_data  = main_d;

    // Main refills from skid first to keep order, else straight from input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_d <= '0;
            skid_d <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (!main_v || drain) begin
            if (skid_v) begin
                main_v <= 1'b1;
                main_d <= skid_d;
                skid_v <= 1'b0;
            end else begin
                main_v <= accept;
                if (accept) main_d <= in_data;
            end
        end else if (accept) begin
            skid_v <= 1'b1;
            skid_d <= in_data;
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution: decodes funct3 against comparator flags, buffers result.
// Define BRANCH_RESOLVE_PERF_EN to add saturating branch/mispredict counters.
module branch_resolve
    import branch_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic            in_eq,
    input  logic            in_lt,
    input  logic            in_ltu,
    input  logic            in_pred_taken,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_target,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic            out_mispredict,
    output logic            out_illegal,
`ifdef BRANCH_RESOLVE_PERF_EN
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts,
`endif
    output logic [XLEN-1:0] out_redirect_pc
);

    logic       taken_c;
    logic       illegal_c;
    br_result_t res_c;
    br_result_t out_q;

    // Direction decode; 010/011 are not branches
    always_comb begin
        taken_c   = 1'b0;
        illegal_c = 1'b0;
        unique case (1'b1)
            in_funct3 == BEQ:  taken_c = in_eq;
            in_funct3 == BNE:  taken_c = ~in_eq;
            in_funct3 == BLT:  taken_c = in_lt;
            in_funct3 == BGE:  taken_c = ~in_lt;
            in_funct3 == BLTU: taken_c = in_ltu;
            in_funct3 == BGEU: taken_c = ~in_ltu;
            default:           illegal_c = 1'b1;
        endcase
    end

    // Pack the result; fall-through PC wraps modulo 2^XLEN
    always_comb begin
        res_c             = '0;
        res_c.taken       = taken_c;
        res_c.illegal     = illegal_c;
        res_c.mispredict  = !illegal_c && (taken_c != in_pred_taken);
        res_c.redirect_pc = taken_c ? in_target : in_pc + XLEN'(4);
    end

    br_skid2 #(
        .T(br_result_t)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (res_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_q)
    );

    assign out_taken       = out_q.taken;
    assign out_mispredict  = out_q.mispredict;
    assign out_illegal     = out_q.illegal;
    assign out_redirect_pc = out_q.redirect_pc;

`ifdef BRANCH_RESOLVE_PERF_EN
    logic done;

    assign done = out_valid && out_ready && !flush && !out_q.illegal;

    // Count legal branches as they leave; a flushed entry never counts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else if (done) begin
            if (perf_branches != '1)
                perf_branches <= perf_branches + 32'd1;
            if (out_q.mispredict && perf_mispredicts != '1)
                perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: decode, wrap, backpressure, flush, reset.
// Counter checks compile in only when BRANCH_RESOLVE_PERF_EN is defined.
module tb_branch_resolve;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic        in_eq;
    logic        in_lt;
    logic        in_ltu;
    logic        in_pred_taken;
    logic [31:0] in_pc;
    logic [31:0] in_target;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic        out_mispredict;
    logic        out_illegal;
    logic [31:0] out_redirect_pc;
`ifdef BRANCH_RESOLVE_PERF_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    branch_resolve dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_funct3       (in_funct3),
        .in_eq           (in_eq),
        .in_lt           (in_lt),
        .in_ltu          (in_ltu),
        .in_pred_taken   (in_pred_taken),
        .in_pc           (in_pc),
        .in_target       (in_target),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_taken       (out_taken),
        .out_mispredict  (out_mispredict),
        .out_illegal     (out_illegal),
`ifdef BRANCH_RESOLVE_PERF_EN
        .perf_branches   (perf_branches),
        .perf_mispredicts(perf_mispredicts),
`endif
        .out_redirect_pc (out_redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic t,
                           input logic m, input logic il,
                           input logic [31:0] pc);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".taken"}, 32'(out_taken), 32'(t));
        chk({tag, ".misp"}, 32'(out_mispredict), 32'(m));
        chk({tag, ".ill"}, 32'(out_illegal), 32'(il));
        chk({tag, ".pc"}, out_redirect_pc, pc);
    endtask

    task automatic drive(input logic [2:0] f3, input logic eq,
                         input logic lt, input logic ltu, input logic pred,
                         input logic [31:0] pc, input logic [31:0] tgt);
        in_valid      = 1'b1;
        in_funct3     = f3;
        in_eq         = eq;
        in_lt         = lt;
        in_ltu        = ltu;
        in_pred_taken = pred;
        in_pc         = pc;
        in_target     = tgt;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_funct3 = 3'b000;
        in_eq     = 1'b0;
        in_lt     = 1'b0;
        in_ltu    = 1'b0;
        in_pred_taken = 1'b0;
        in_pc     = 32'h0;
        in_target = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("rst.rdy", 32'(in_ready), 32'd1);
`ifdef BRANCH_RESOLVE_PERF_EN
        chk("rst.pb", perf_branches, 32'd0);
        chk("rst.pm", perf_mispredicts, 32'd0);
`endif
        reset_n = 1'b1;
        tick();

        drive(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h200);
        chk("beq.rdy", 32'(in_ready), 32'd1);
        tick();
        chk_out("beq", 1'b1, 1'b1, 1'b1, 1'b0, 32'h200);
        drive(3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h40);
        tick();
        chk_out("bgeu", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 32'h900);
        tick();
        chk_out("bne", 1'b1, 1'b0, 1'b1, 1'b0, 32'h304);
        drive(3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 32'h400, 32'h80);
        tick();
        chk_out("blt", 1'b1, 1'b1, 1'b0, 1'b0, 32'h80);
        drive(3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h70);
        tick();
        chk_out("bge", 1'b1, 1'b0, 1'b0, 1'b0, 32'h14);
        drive(3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h1234);
        tick();
        chk_out("bltu", 1'b1, 1'b1, 1'b1, 1'b0, 32'h1234);
        drive(3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 32'h500, 32'h600);
        tick();
        chk_out("il010", 1'b1, 1'b0, 1'b0, 1'b1, 32'h504);
        drive(3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 32'h700, 32'h800);
        tick();
        chk_out("il011", 1'b1, 1'b0, 1'b0, 1'b1, 32'h704);
        in_valid = 1'b0;
        tick();
        chk("idle.v", 32'(out_valid), 32'd0);
`ifdef BRANCH_RESOLVE_PERF_EN
        chk("dir.pb", perf_branches, 32'd6);
        chk("dir.pm", perf_mispredicts, 32'd3);
`endif

        out_ready = 1'b0;
        drive(3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1000, 32'h2000);
        chk("bp0.rdy", 32'(in_ready), 32'd1);
        tick();
        chk_out("bpA0", 1'b1, 1'b1, 1'b0, 1'b0, 32'h2000);
        chk("bp1.rdy", 32'(in_ready), 32'd1);
        drive(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1100, 32'h3000);
        tick();
        chk_out("bpA1", 1'b1, 1'b1, 1'b0, 1'b0, 32'h2000);
        chk("bp2.rdy", 32'(in_ready), 32'd0);
        drive(3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1200, 32'h4000);
        tick();
        chk_out("bpA2", 1'b1, 1'b1, 1'b0, 1'b0, 32'h2000);
        chk("bp3.rdy", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        chk_out("bpB", 1'b1, 1'b0, 1'b0, 1'b0, 32'h1104);
        chk("bp4.rdy", 32'(in_ready), 32'd1);
        tick();
        chk_out("bpC", 1'b1, 1'b0, 1'b0, 1'b0, 32'h1204);
        in_valid = 1'b0;
        tick();
        chk("bp.end", 32'(out_valid), 32'd0);
`ifdef BRANCH_RESOLVE_PERF_EN
        chk("bp.pb", perf_branches, 32'd9);
        chk("bp.pm", perf_mispredicts, 32'd3);
`endif

        out_ready = 1'b0;
        drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h50);
        tick();
        drive(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h60, 32'h90);
        tick();
        chk("fl.v0", 32'(out_valid), 32'd1);
        chk("fl.rdy0", 32'(in_ready), 32'd0);
        chk("fl.pc0", out_redirect_pc, 32'h44);
        flush = 1'b1;
        drive(3'b110, 1'b0, 1'b0, 1'b1, 1'b1, 32'h70, 32'hA0);
        #1;
        chk("fl.rdyf", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("fl.v1", 32'(out_valid), 32'd0);
        chk("fl.rdy1", 32'(in_ready), 32'd1);
        tick();
        chk("fl.v2", 32'(out_valid), 32'd0);
`ifdef BRANCH_RESOLVE_PERF_EN
        chk("fl.pb", perf_branches, 32'd9);
        chk("fl.pm", perf_mispredicts, 32'd3);
`endif

        out_ready = 1'b1;
        drive(3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 32'h800, 32'hC00);
        tick();
        chk_out("g", 1'b1, 1'b1, 1'b0, 1'b0, 32'hC00);
        in_valid = 1'b0;
        tick();
`ifdef BRANCH_RESOLVE_PERF_EN
        chk("ten.pb", perf_branches, 32'd10);
        chk("ten.pm", perf_mispredicts, 32'd3);
`endif

        out_ready = 1'b0;
        drive(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h900, 32'hB00);
        tick();
        chk("mr.v0", 32'(out_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_out("mr", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("mr.rdy", 32'(in_ready), 32'd1);
`ifdef BRANCH_RESOLVE_PERF_EN
        chk("mr.pb", perf_branches, 32'd0);
        chk("mr.pm", perf_mispredicts, 32'd0);
`endif
        in_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("mr.v1", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
